// File: rtl/sound_player.sv
//------------------------------------------------------------------------------
// sound_player: turns request-level rising edges into fixed-length square-wave
// bursts on one speaker pin. Optional macro: SOUND_RETRIGGER_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sound_player #(
  parameter int TONE1_HALF      = 14204,
  parameter int TONE2_HALF      = 28409,
  parameter int DURATION_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_sound1,
  input  logic       play_sound2,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] tone_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY1 = 2'd1,
    PLAY2 = 2'd2
  } state_t;

  localparam logic [21:0] DUR_LAST   = 22'(DURATION_CYCLES - 1);
  localparam logic [15:0] HALF1_LAST = 16'(TONE1_HALF - 1);
  localparam logic [15:0] HALF2_LAST = 16'(TONE2_HALF - 1);

  state_t      state_q, state_d;
  logic        prev1_q, prev2_q;
  logic [21:0] dur_q, dur_d;
  logic [15:0] half_q, half_d;
  logic        speaker_q, speaker_d;
  logic        busy_q, busy_d;
  logic [1:0]  tone_q, tone_d;

  logic        rise1, rise2, start, dur_last, half_last;

  assign rise1     = play_sound1 & ~prev1_q;
  assign rise2     = play_sound2 & ~prev2_q;
  assign dur_last  = (dur_q == DUR_LAST);
  assign half_last = (state_q == PLAY1) ? (half_q == HALF1_LAST)
                                        : (half_q == HALF2_LAST);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise2) begin
          state_d = PLAY2;
          start   = 1'b1;
        end else if (rise1) begin
          state_d = PLAY1;
          start   = 1'b1;
        end
      end
      PLAY1, PLAY2: begin
`ifdef SOUND_RETRIGGER_EN
        if (rise2) begin
          state_d = PLAY2;
          start   = 1'b1;
        end else if (rise1) begin
          state_d = PLAY1;
          start   = 1'b1;
        end else if (dur_last) begin
          state_d = IDLE;
        end
`else
        // Edges mid-burst are dropped; only the final cycle chains a new burst.
        if (dur_last) begin
          if (rise2) begin
            state_d = PLAY2;
            start   = 1'b1;
          end else if (rise1) begin
            state_d = PLAY1;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dur_d     = dur_q;
    half_d    = half_q;
    speaker_d = speaker_q;
    if (start || state_d == IDLE) begin
      dur_d     = '0;
      half_d    = '0;
      speaker_d = 1'b0;
    end else begin
      dur_d = dur_q + 22'd1;
      if (half_last) begin
        half_d    = '0;
        speaker_d = ~speaker_q;
      end else begin
        half_d = half_q + 16'd1;
      end
    end
    busy_d = (state_d != IDLE);
    case (state_d)
      PLAY1:   tone_d = 2'd1;
      PLAY2:   tone_d = 2'd2;
      default: tone_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    prev1_q <= play_sound1;
    prev2_q <= play_sound2;
    if (reset) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      half_q    <= '0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
      tone_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      half_q    <= half_d;
      speaker_q <= speaker_d;
      busy_q    <= busy_d;
      tone_q    <= tone_d;
    end
  end

  assign speaker = speaker_q;
  assign busy    = busy_q;
  assign tone_id = tone_q;

endmodule

`default_nettype wire

// File: tb/tb_sound_player.sv
//------------------------------------------------------------------------------
// tb_sound_player: directed vector table plus multi-cycle burst sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sound_player;

  localparam int T1 = 4;
  localparam int T2 = 8;
  localparam int D  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_sound1 = 1'b0;
  logic       play_sound2 = 1'b0;
  logic       speaker;
  logic       busy;
  logic [1:0] tone_id;

  int n_tests = 0;
  int n_fail  = 0;

  sound_player #(
    .TONE1_HALF(T1),
    .TONE2_HALF(T2),
    .DURATION_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .play_sound1(play_sound1),
    .play_sound2(play_sound2),
    .speaker(speaker),
    .busy(busy),
    .tone_id(tone_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       p1;
    logic       p2;
    logic       spk;
    logic       bsy;
    logic [1:0] tid;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] exp);
    logic [3:0] act;
    act = {speaker, busy, tone_id};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {spk,busy,tone}=%b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] play_exp(input int k0, input int half, input int tone);
    logic s;
    s = (((k0 / half) % 2) == 1);
    return {s, 1'b1, tone[1:0]};
  endfunction

  initial begin
    vec_t vecs[17];
    int   rises;
    logic prev_s;

    //          rst   p1    p2    spk   busy  tone
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    for (int i = 0; i < 17; i++) begin
      reset       = vecs[i].rst;
      play_sound1 = vecs[i].p1;
      play_sound2 = vecs[i].p2;
      tick();
      chk($sformatf("vec%0d", i), {vecs[i].spk, vecs[i].bsy, vecs[i].tid});
    end

    // Reset held 3 cycles with play_sound1 high, then 50 quiet cycles.
    reset = 1'b1; play_sound1 = 1'b1; play_sound2 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk($sformatf("reset_hold c%0d", k), 4'b0000);
    end

    // Single tone-1 burst.
    play_sound1 = 1'b0; tick();
    play_sound1 = 1'b1; tick();
    rises  = 0;
    prev_s = 1'b0;
    for (int k = 1; k <= D; k++) begin
      chk($sformatf("tone1 c%0d", k), play_exp(k - 1, T1, 1));
      if (speaker === 1'b1 && prev_s === 1'b0) rises++;
      prev_s = speaker;
      tick();
    end
    chk("tone1 end", 4'b0000);
    n_tests++;
    if (rises != 5) begin
      n_fail++;
      $display("FAIL tone1 rises: got %0d expected 5", rises);
    end

    // play_sound2 held high 100 cycles: one burst only.
    play_sound1 = 1'b0; play_sound2 = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      if (k <= D) chk($sformatf("held2 c%0d", k), play_exp(k - 1, T2, 2));
      else        chk($sformatf("held2 c%0d", k), 4'b0000);
      tick();
    end
    play_sound2 = 1'b0; tick();

    // Simultaneous rise: tone 2 wins, no tone-1 burst follows.
    play_sound1 = 1'b1; play_sound2 = 1'b1;
    tick();
    for (int k = 1; k <= D + 20; k++) begin
      if (k <= D) chk($sformatf("simul c%0d", k), play_exp(k - 1, T2, 2));
      else        chk($sformatf("simul c%0d", k), 4'b0000);
      tick();
    end
    play_sound1 = 1'b0; play_sound2 = 1'b0; tick();

    // Mid-burst edges: rise1 sampled at end of cycle 10, rise2 at end of cycle 20.
    play_sound1 = 1'b1; tick();
    for (int k = 1; k <= 75; k++) begin
      logic [3:0] e;
`ifdef SOUND_RETRIGGER_EN
      if (k <= 10)      e = play_exp(k - 1, T1, 1);
      else if (k <= 20) e = play_exp(k - 11, T1, 1);
      else if (k <= 60) e = play_exp(k - 21, T2, 2);
      else              e = 4'b0000;
`else
      if (k <= D) e = play_exp(k - 1, T1, 1);
      else        e = 4'b0000;
`endif
      chk($sformatf("midburst c%0d", k), e);
      play_sound1 = !(k == 8 || k == 9);
      play_sound2 = (k >= 20);
      tick();
    end
    play_sound1 = 1'b0; play_sound2 = 1'b0; tick();

    // Back-to-back: rise2 in the final cycle of a tone-1 burst.
    play_sound1 = 1'b1; tick();
    for (int k = 1; k <= 85; k++) begin
      logic [3:0] e;
      if (k <= D)         e = play_exp(k - 1, T1, 1);
      else if (k <= 2 * D) e = play_exp(k - D - 1, T2, 2);
      else                e = 4'b0000;
      chk($sformatf("b2b c%0d", k), e);
      play_sound2 = (k >= D);
      tick();
    end
    play_sound1 = 1'b0; play_sound2 = 1'b0; tick();

    // Reset at burst cycle 15; nothing resumes afterwards.
    play_sound1 = 1'b1; tick();
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("rstmid c%0d", k), play_exp(k - 1, T1, 1));
      if (k == 15) reset = 1'b1;
      tick();
    end
    chk("rstmid abort", 4'b0000);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk($sformatf("rstmid after c%0d", k), 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
